vga_fill_engine: RTL and testbench
==================================

// Module: vga_fill_engine
// PURPOSE
//  Rectangle-fill and buffer-swap sequencer in front of the double-buffered 640x480 1-bpp framebuffer.
//  Accepts fill commands and streams one pixel write per granted cycle onto the framebuffer write bus.
//  Shares that bus with CPU stores through a starvation-bounded arbiter.
//  Optionally ends a command with the swap store, address 24'hfffffc.
// PARAMETERS
//  H_RES      640  visible width; x clamp limit
//  V_RES      480  visible height; y clamp limit
//  MAX_STALL  4    max consecutive cycles the engine yields to CPU before forcing a grant; 0 = engine always wins
// PORTS
//  clk          in   1   system clock, same clock as the framebuffer write port
//  reset        in   1   synchronous, active-high
//  cmd_valid    in   1   command offered
//  cmd_ready    out  1   engine idle, can accept a command
//  cmd_x0/x1    in   10  inclusive x range
//  cmd_y0/y1    in   10  inclusive y range
//  cmd_color    in   1   pixel value to write
//  cmd_fill     in   1   1 = perform the rectangle fill
//  cmd_swap     in   1   1 = issue the swap store after the fill (or alone)
//  cpu_addr     in   24  CPU store address
//  cpu_datain   in   32  CPU store data
//  cpu_we       in   1   CPU store strobe
//  cpu_stall    out  1   CPU store blocked this cycle; CPU holds its store
//  fb_addr      out  24  framebuffer bus address
//  fb_datain    out  32  framebuffer bus data
//  fb_we        out  1   framebuffer bus write strobe
//  busy         out  1   state != IDLE
//  done         out  1   one-cycle pulse when a command completes
// BEHAVIOUR
//  Reset: state=IDLE, stall_cnt=0. While reset is high: fb_we=0, cpu_stall=0, done=0, busy=0, cmd_ready=0.
//  Reset applied mid-command aborts it. No further engine writes; no done pulse.
//  FSM states: IDLE, FILL, SWAP.
//  - IDLE: cmd_ready=1. On cmd_valid, capture the command.
//    - Latch x1c=min(x1,H_RES-1) and y1c=min(y1,V_RES-1). Set x=x0, y=y0.
//    - Next state: FILL if cmd_fill and x0<=x1c and y0<=y1c; else SWAP if cmd_swap; else stay IDLE and pulse done next cycle.
//    - An empty or inverted rectangle produces zero pixel writes.
//  - FILL: engine request = 1.
//    - Granted write: fb_addr={4'h0,y,x}, fb_datain={31'b0,color}.
//    - Raster order: x increments; at x==x1c, x<=x0 and y increments.
//    - After the grant at (x1c,y1c): go to SWAP if cmd_swap, else IDLE with done.
//  - SWAP: request the store fb_addr=24'hfffffc, fb_datain=0. When granted, go to IDLE with done.
//  - done asserts in the cycle after the final granted write, coincident with return to IDLE.
//  Arbitration, combinational, same cycle:
//    - engine_grant = req & (~cpu_we | stall_cnt==MAX_STALL).
//    - cpu_stall = cpu_we & engine_grant.
//    - fb_* carries engine values when engine_grant; otherwise CPU values with fb_we=cpu_we.
//    - stall_cnt increments when req & cpu_we & ~engine_grant, saturating at MAX_STALL.
//    - stall_cnt clears on engine_grant or when req=0.
//  Throughput: 1 pixel/cycle with no CPU traffic.
//    - Full screen = 307200 writes.
//    - Under continuous CPU stores: 1 write per MAX_STALL+1 cycles.
//  cmd_valid while busy is ignored (cmd_ready=0). Commands are not queued.
//  CPU stores to any address, including fffffc, pass through unchanged whenever not stalled.
// TESTING
//  1. Fill (2,1)-(4,2), color 1, no CPU traffic -> 6 writes on consecutive cycles.
//     Addresses {1,2},{1,3},{1,4},{2,2},{2,3},{2,4}, data 1. done the next cycle.
//  2. Swap-only command -> exactly one write, addr fffffc. done the cycle after. No pixel writes.
//  3. Fill (0,0)-(9,0) with cpu_we held high, MAX_STALL=4:
//     -> engine write and cpu_stall=1 every 5th cycle. CPU stores appear on the other 4 cycles.
//  4. x1=700, y0=y1=479 -> writes x 0..639 at y=479, then done.
//     x0=5, x1=3 -> zero writes, done 1 cycle after accept.
//  5. Reset asserted after 3rd pixel of a 100-pixel fill -> fb_we=0 during reset, no done pulse.
//     After reset deasserts: cmd_ready=1, busy=0.
//  6. Fill (0,0)-(1,1) plus swap -> 4 pixel writes, then fffffc on the next granted cycle, then done.

Source files
------------

// File: rtl/vga_fill_if.sv
// Command, CPU-store and framebuffer-write signals of the fill engine.
// cmd: a command transfers on a rising clk edge where cmd_valid && cmd_ready; cmd_valid while not ready is dropped.
interface vga_fill_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [9:0]  cmd_x0;
  logic [9:0]  cmd_x1;
  logic [9:0]  cmd_y0;
  logic [9:0]  cmd_y1;
  logic        cmd_color;
  logic        cmd_fill;
  logic        cmd_swap;
  logic [23:0] cpu_addr;
  logic [31:0] cpu_datain;
  logic        cpu_we;
  logic        cpu_stall;
  logic [23:0] fb_addr;
  logic [31:0] fb_datain;
  logic        fb_we;

  modport master (
    output cmd_valid, cmd_x0, cmd_x1, cmd_y0, cmd_y1, cmd_color, cmd_fill, cmd_swap,
    input  cmd_ready,
    output cpu_addr, cpu_datain, cpu_we,
    input  cpu_stall,
    input  fb_addr, fb_datain, fb_we
  );

  modport slave (
    input  cmd_valid, cmd_x0, cmd_x1, cmd_y0, cmd_y1, cmd_color, cmd_fill, cmd_swap,
    output cmd_ready,
    input  cpu_addr, cpu_datain, cpu_we,
    output cpu_stall,
    output fb_addr, fb_datain, fb_we
  );
endinterface

// File: rtl/vga_fill_engine.sv
// Rectangle fill / buffer swap sequencer sharing the framebuffer write bus with CPU stores
// through a starvation-bounded arbiter.
module vga_fill_engine #(
  parameter int H_RES     = 640,
  parameter int V_RES     = 480,
  parameter int MAX_STALL = 4
) (
  input  logic       clk,
  input  logic       reset,
  vga_fill_if.slave  bus,
  output logic       busy,
  output logic       done,
  output logic [1:0] state_dbg
);

  localparam int SW = (MAX_STALL < 2) ? 1 : $clog2(MAX_STALL + 1);
  localparam logic [23:0] SWAP_ADDR = 24'hfffffc;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    SWAP = 2'd2
  } state_t;

  state_t        state, state_n;
  logic [9:0]    x, y, x0_q, x1c_q, y1c_q;
  logic          color_q, swap_q;
  logic [SW-1:0] stall_cnt;
  logic          done_q, done_n;

  logic          accept, req, at_max, engine_grant, last_px;
  logic [9:0]    x1c_in, y1c_in;

  assign accept  = (state == IDLE) && bus.cmd_valid;
  assign x1c_in  = (bus.cmd_x1 > 10'(H_RES - 1)) ? 10'(H_RES - 1) : bus.cmd_x1;
  assign y1c_in  = (bus.cmd_y1 > 10'(V_RES - 1)) ? 10'(V_RES - 1) : bus.cmd_y1;
  assign req     = (state != IDLE);
  assign at_max  = (stall_cnt == SW'(MAX_STALL));
  assign engine_grant = req && (!bus.cpu_we || at_max);
  assign last_px = (x == x1c_q) && (y == y1c_q);

  always_comb begin
    state_n = state;
    done_n  = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (bus.cmd_fill && (bus.cmd_x0 <= x1c_in) && (bus.cmd_y0 <= y1c_in)) begin
            state_n = FILL;
          end else if (bus.cmd_swap) begin
            state_n = SWAP;
          end else begin
            done_n = 1'b1;
          end
        end
      end
      FILL: begin
        if (engine_grant && last_px) begin
          if (swap_q) begin
            state_n = SWAP;
          end else begin
            state_n = IDLE;
            done_n  = 1'b1;
          end
        end
      end
      SWAP: begin
        if (engine_grant) begin
          state_n = IDLE;
          done_n  = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      stall_cnt <= '0;
      done_q    <= 1'b0;
      x         <= '0;
      y         <= '0;
      x0_q      <= '0;
      x1c_q     <= '0;
      y1c_q     <= '0;
      color_q   <= 1'b0;
      swap_q    <= 1'b0;
    end else begin
      state  <= state_n;
      done_q <= done_n;

      // Count only cycles the engine actually yielded; any grant or idle period restarts the count.
      if (!req || engine_grant) begin
        stall_cnt <= '0;
      end else if (bus.cpu_we && !at_max) begin
        stall_cnt <= stall_cnt + SW'(1);
      end

      if (accept) begin
        x       <= bus.cmd_x0;
        y       <= bus.cmd_y0;
        x0_q    <= bus.cmd_x0;
        x1c_q   <= x1c_in;
        y1c_q   <= y1c_in;
        color_q <= bus.cmd_color;
        swap_q  <= bus.cmd_swap;
      end else if ((state == FILL) && engine_grant) begin
        if (x == x1c_q) begin
          x <= x0_q;
          y <= y + 10'd1;
        end else begin
          x <= x + 10'd1;
        end
      end
    end
  end

  // Outputs are forced quiet while reset is held, even before the first reset edge.
  always_comb begin
    bus.cmd_ready = !reset && (state == IDLE);
    busy          = !reset && req;
    done          = !reset && done_q;
    bus.cpu_stall = !reset && bus.cpu_we && engine_grant;
    if (reset) begin
      bus.fb_we     = 1'b0;
      bus.fb_addr   = bus.cpu_addr;
      bus.fb_datain = bus.cpu_datain;
    end else if (engine_grant) begin
      bus.fb_we     = 1'b1;
      bus.fb_addr   = (state == SWAP) ? SWAP_ADDR : {4'h0, y, x};
      bus.fb_datain = (state == SWAP) ? 32'd0 : {31'd0, color_q};
    end else begin
      bus.fb_we     = bus.cpu_we;
      bus.fb_addr   = bus.cpu_addr;
      bus.fb_datain = bus.cpu_datain;
    end
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_vga_fill_engine.sv
// Bench for vga_fill_engine: rectangle/arbitration model checked every cycle plus literal pins.
module tb_vga_fill_engine;

  localparam int MAX_STALL = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       busy, done;
  logic [1:0] state_dbg;

  vga_fill_if bus();

  vga_fill_engine #(.H_RES(640), .V_RES(480), .MAX_STALL(MAX_STALL)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .busy      (busy),
    .done      (done),
    .state_dbg (state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation reached time limit at cycle %0d", cyc);
    $fatal(1, "time limit");
  end

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt = 0;
  int done_cyc = -1;
  int acc_cyc  = -1;
  int done_base = 0;
  int cpu_mode = 0;

  logic [24:0] exp_q[$];
  logic [23:0] wr_log[$];
  int          wr_cyc[$];
  int          m_stall = 0;
  bit          done_exp = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // ---------------- CPU traffic driver ----------------
  initial begin
    bus.cpu_we     = 1'b0;
    bus.cpu_addr   = '0;
    bus.cpu_datain = '0;
    forever begin
      @(posedge clk);
      #1;
      case (cpu_mode)
        1: begin
          bus.cpu_we     = 1'b1;
          bus.cpu_addr   = 24'hfffffc;
          bus.cpu_datain = 32'hdeadbeef;
        end
        2: begin
          bus.cpu_we     = 1'($urandom_range(0, 1));
          bus.cpu_addr   = 24'($urandom);
          bus.cpu_datain = $urandom;
        end
        default: bus.cpu_we = 1'b0;
      endcase
    end
  end

  // ---------------- model + per-cycle compare ----------------
  always @(negedge clk) begin
    bit          idle_now, grant_e;
    logic [24:0] head;
    int          x1c, y1c;
    if (reset) begin
      chk("rst_fb_we",     bus.fb_we, 0);
      chk("rst_cpu_stall", bus.cpu_stall, 0);
      chk("rst_done",      done, 0);
      chk("rst_busy",      busy, 0);
      chk("rst_cmd_ready", bus.cmd_ready, 0);
      exp_q.delete();
      m_stall  = 0;
      done_exp = 1'b0;
    end else begin
      idle_now = (exp_q.size() == 0);
      chk("cmd_ready", bus.cmd_ready, idle_now);
      chk("busy", busy, !idle_now);
      chk("done", done, done_exp);
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      done_exp = 1'b0;
      grant_e = !idle_now && (!bus.cpu_we || m_stall == MAX_STALL);
      chk("cpu_stall", bus.cpu_stall, bus.cpu_we && grant_e);
      if (grant_e) begin
        head = exp_q.pop_front();
        chk("eng_we",   bus.fb_we, 1);
        chk("eng_addr", bus.fb_addr, head[23:0]);
        chk("eng_data", bus.fb_datain, {31'd0, head[24]});
        wr_log.push_back(bus.fb_addr);
        wr_cyc.push_back(cyc);
        if (exp_q.size() == 0) done_exp = 1'b1;
        m_stall = 0;
      end else begin
        chk("cpu_we_pass",   bus.fb_we, bus.cpu_we);
        chk("cpu_addr_pass", bus.fb_addr, bus.cpu_addr);
        chk("cpu_data_pass", bus.fb_datain, bus.cpu_datain);
        if (!idle_now && bus.cpu_we) m_stall = (m_stall < MAX_STALL) ? m_stall + 1 : MAX_STALL;
        else m_stall = 0;
      end
      if (bus.cmd_valid && idle_now) begin
        acc_cyc = cyc;
        x1c = (bus.cmd_x1 > 639) ? 639 : int'(bus.cmd_x1);
        y1c = (bus.cmd_y1 > 479) ? 479 : int'(bus.cmd_y1);
        if (bus.cmd_fill) begin
          for (int yy = int'(bus.cmd_y0); yy <= y1c; yy++)
            for (int xx = int'(bus.cmd_x0); xx <= x1c; xx++)
              exp_q.push_back({bus.cmd_color, 4'h0, 10'(yy), 10'(xx)});
        end
        if (bus.cmd_swap) exp_q.push_back({1'b0, 24'hfffffc});
        if (exp_q.size() == 0) done_exp = 1'b1;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input int x0, input int x1, input int y0, input int y1,
                      input bit color, input bit fill, input bit swap);
    @(posedge clk);
    #1;
    wr_log.delete();
    wr_cyc.delete();
    done_base     = done_cnt;
    bus.cmd_valid = 1'b1;
    bus.cmd_x0    = 10'(x0);
    bus.cmd_x1    = 10'(x1);
    bus.cmd_y0    = 10'(y0);
    bus.cmd_y1    = 10'(y1);
    bus.cmd_color = color;
    bus.cmd_fill  = fill;
    bus.cmd_swap  = swap;
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input string nm, input int budget);
    int n = 0;
    while (done_cnt == done_base && n < budget) begin
      @(posedge clk);
      n++;
    end
    if (done_cnt == done_base) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_timeout: no done within %0d cycles", nm, budget);
    end
  endtask

  task automatic wait_writes(input int cnt, input int budget);
    int n = 0;
    while (wr_log.size() < cnt && n < budget) begin
      @(posedge clk);
      n++;
    end
    if (wr_log.size() < cnt) begin
      n_checks++;
      n_fail++;
      $display("FAIL writes_timeout: got %0d writes expected %0d", wr_log.size(), cnt);
    end
  endtask

  // ---------------- directed stimulus ----------------
  logic [23:0] t1_addr[6] = '{24'h000402, 24'h000403, 24'h000404,
                              24'h000802, 24'h000803, 24'h000804};
  logic [23:0] t6_addr[5] = '{24'h000000, 24'h000001, 24'h000400,
                              24'h000401, 24'hfffffc};

  initial begin
    int d0;
    reset         = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_x0    = '0;
    bus.cmd_x1    = '0;
    bus.cmd_y0    = '0;
    bus.cmd_y1    = '0;
    bus.cmd_color = 1'b0;
    bus.cmd_fill  = 1'b0;
    bus.cmd_swap  = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // 1: small fill, no CPU traffic
    send(2, 4, 1, 2, 1'b1, 1'b1, 1'b0);
    wait_done("t1", 50);
    chk("t1_count", wr_log.size(), 6);
    for (int i = 0; i < 6 && i < wr_log.size(); i++) chk("t1_addr", wr_log[i], t1_addr[i]);
    if (wr_log.size() == 6) begin
      chk("t1_consecutive", wr_cyc[5] - wr_cyc[0], 5);
      chk("t1_done_cyc", done_cyc, wr_cyc[5] + 1);
    end

    // 2: swap only
    send(0, 0, 0, 0, 1'b0, 1'b0, 1'b1);
    wait_done("t2", 50);
    chk("t2_count", wr_log.size(), 1);
    if (wr_log.size() == 1) begin
      chk("t2_addr", wr_log[0], 24'hfffffc);
      chk("t2_done_cyc", done_cyc, wr_cyc[0] + 1);
    end

    // 3: fill under continuous CPU stores
    cpu_mode = 1;
    send(0, 9, 0, 0, 1'b1, 1'b1, 1'b0);
    wait_done("t3", 200);
    cpu_mode = 0;
    chk("t3_count", wr_log.size(), 10);
    if (wr_log.size() == 10) begin
      chk("t3_first", wr_cyc[0], acc_cyc + 5);
      chk("t3_spacing", wr_cyc[1] - wr_cyc[0], 5);
      chk("t3_span", wr_cyc[9] - wr_cyc[0], 45);
      chk("t3_last_addr", wr_log[9], 24'h000009);
    end

    // 4: x clamp on last row, with an ignored command mid-fill
    send(0, 700, 479, 479, 1'b1, 1'b1, 1'b0);
    wait_writes(100, 300);
    @(posedge clk); #1;
    bus.cmd_valid = 1'b1;
    bus.cmd_x0 = 10'd7; bus.cmd_x1 = 10'd8; bus.cmd_y0 = 10'd0; bus.cmd_y1 = 10'd0;
    bus.cmd_swap = 1'b1;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    wait_done("t4", 1000);
    chk("t4_count", wr_log.size(), 640);
    if (wr_log.size() == 640) begin
      chk("t4_first", wr_log[0], 24'h077c00);
      chk("t4_last", wr_log[639], 24'h077e7f);
    end

    // 4b: inverted rectangle
    send(5, 3, 0, 0, 1'b1, 1'b1, 1'b0);
    wait_done("t4b", 20);
    chk("t4b_count", wr_log.size(), 0);
    chk("t4b_done_cyc", done_cyc, acc_cyc + 1);

    // 5: reset after third pixel of a 100-pixel fill
    send(0, 99, 0, 0, 1'b1, 1'b1, 1'b0);
    wait_writes(3, 50);
    d0 = done_cnt;
    #1 reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    repeat (5) @(posedge clk);
    chk("t5_writes", wr_log.size(), 3);
    chk("t5_no_done", done_cnt, d0);
    @(negedge clk);
    chk("t5_ready", bus.cmd_ready, 1);
    chk("t5_busy", busy, 0);

    // 6: 2x2 fill plus swap
    send(0, 1, 0, 1, 1'b1, 1'b1, 1'b1);
    wait_done("t6", 50);
    chk("t6_count", wr_log.size(), 5);
    for (int i = 0; i < 5 && i < wr_log.size(); i++) chk("t6_addr", wr_log[i], t6_addr[i]);
    if (wr_log.size() == 5) begin
      chk("t6_span", wr_cyc[4] - wr_cyc[0], 4);
      chk("t6_done_cyc", done_cyc, wr_cyc[4] + 1);
    end

    // 6b: fill plus swap under random CPU traffic
    cpu_mode = 2;
    send(3, 6, 2, 4, 1'b0, 1'b1, 1'b1);
    wait_done("t6b", 300);
    cpu_mode = 0;
    chk("t6b_count", wr_log.size(), 13);
    if (wr_log.size() == 13) chk("t6b_swap", wr_log[12], 24'hfffffc);

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
